// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the RV32I core.
// One request is accepted on a valid/ready channel. After a fixed number of
// wait states the byte-enabled write is committed or the read word is fetched,
// and the response is held on a valid/ready channel until it is taken.
module dmem_responder #(
    parameter int          MEM_DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES     = 1,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_wr_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    input  logic [3:0]  req_wstrb_in,
    output logic        rsp_valid_out,
    input  logic        rsp_ready_in,
    output logic [31:0] rsp_rdata_out,
    output logic        rsp_err_out
);

    localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

    // WAIT is always entered on accept: one cycle to hold the latched request,
    // then WAIT_CYCLES wait states. This places RESP entry (memory access and
    // rsp_valid rise) exactly WAIT_CYCLES+1 edges after the accept edge.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic               err_q, err_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rd_sel_q, rd_sel_d;

    logic [31:0]        mem [MEM_DEPTH_WORDS];
    logic [31:0]        mem_rdata_q;

    logic [31:0]        addr_off;
    logic               acc_err;
    logic [IDX_W-1:0]   acc_idx;
    logic               accept;
    logic               enter_resp;
    logic               mem_en;

    // Decode the incoming address: offset from base, error checks, word index.
    // BASE_ADDR is word aligned, so the offset's low bits equal the address's.
    always_comb begin
        addr_off = req_addr_in - BASE_ADDR;
        acc_err  = (addr_off[1:0] != 2'b00)
                || (req_addr_in < BASE_ADDR)
                || ((addr_off >> 2) >= 32'(MEM_DEPTH_WORDS));
        acc_idx  = addr_off[IDX_W+1:2];
    end

    assign accept     = req_valid_in & req_ready_q;
    assign enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
    // Reset on the would-be commit edge wins, so the write is dropped.
    assign mem_en     = enter_resp & ~rst & ~err_q;

    // Next-state and next-output computation for the request/response FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rd_sel_d    = rd_sel_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                    wr_d    = req_wr_in;
                    idx_d   = acc_idx;
                    wdata_d = req_wdata_in;
                    wstrb_d = req_wstrb_in;
                    err_d   = acc_err;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rd_sel_d    = ~wr_q & ~err_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_in) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rd_sel_d    = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rd_sel_d    = 1'b0;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // FSM state and registered outputs; reset aborts any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_sel_q    <= rd_sel_d;
        end
    end

    // Single-port synchronous RAM: one byte-enabled access at RESP entry.
    always_ff @(posedge clk) begin
        if (mem_en) begin
            if (wr_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
            mem_rdata_q <= mem[idx_q];
        end
    end

    assign req_ready_out = req_ready_q;
    assign rsp_valid_out = rsp_valid_q;
    assign rsp_err_out   = rsp_err_q;
    // RAM output register is not reset; gate it so writes/errors/idle show 0.
    assign rsp_rdata_out = rd_sel_q ? mem_rdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES = 1, 3, 0) driven by
// directed transactions, a reference model of the memory and handshake timing
// checked every cycle, and literal expectations for each transaction.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] DEPTH = 32'd1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wr    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wstrb [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        dmem_responder #(
            .MEM_DEPTH_WORDS(1024),
            .WAIT_CYCLES    ((g == 0) ? 1 : (g == 1) ? 3 : 0),
            .BASE_ADDR      (32'h0000_0000)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid_in (req_valid[g]),
            .req_ready_out(req_ready[g]),
            .req_wr_in    (req_wr[g]),
            .req_addr_in  (req_addr[g]),
            .req_wdata_in (req_wdata[g]),
            .req_wstrb_in (req_wstrb[g]),
            .rsp_valid_out(rsp_valid[g]),
            .rsp_ready_in (rsp_ready[g]),
            .rsp_rdata_out(rsp_rdata[g]),
            .rsp_err_out  (rsp_err[g])
        );
    end

    function automatic int wc(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_busy  [3];
    int          m_cyc   [3];
    bit          m_wr    [3];
    logic [31:0] m_addr  [3];
    logic [31:0] m_wdata [3];
    logic [3:0]  m_strb  [3];
    bit          m_err   [3];
    logic [31:0] m_rdata [3];
    bit          m_known [3];
    logic [31:0] mm [int];

    function automatic bit addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
    endfunction

    task automatic resolve(input int i);
        int key;
        logic [31:0] w;
        m_rdata[i] = 32'd0;
        m_known[i] = 1'b1;
        if (m_err[i]) return;
        key = i * 4096 + int'((m_addr[i] - BASE) >> 2);
        if (m_wr[i]) begin
            w = mm.exists(key) ? mm[key] : 32'd0;
            for (int b = 0; b < 4; b++)
                if (m_strb[i][b]) w[8*b +: 8] = m_wdata[i][8*b +: 8];
            mm[key] = w;
        end else if (mm.exists(key)) begin
            m_rdata[i] = mm[key];
        end else begin
            m_known[i] = 1'b0;
        end
    endtask

    // Advance the model on each rising edge using the pre-edge inputs.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
            end else if (!m_busy[i]) begin
                if (req_valid[i]) begin
                    m_busy[i]  = 1'b1;
                    m_cyc[i]   = 0;
                    m_wr[i]    = req_wr[i];
                    m_addr[i]  = req_addr[i];
                    m_wdata[i] = req_wdata[i];
                    m_strb[i]  = req_wstrb[i];
                    m_err[i]   = addr_err(req_addr[i]);
                end
            end else if (m_cyc[i] < wc(i) + 1) begin
                m_cyc[i]++;
                if (m_cyc[i] == wc(i) + 1) resolve(i);
            end else if (rsp_ready[i]) begin
                m_busy[i] = 1'b0;
            end
        end
    end

    // Compare every instance against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                bit rv;
                rv = m_busy[i] && (m_cyc[i] == wc(i) + 1);
                chk($sformatf("m%0d_ready", i), 32'(req_ready[i]), 32'(!m_busy[i]));
                chk($sformatf("m%0d_valid", i), 32'(rsp_valid[i]), 32'(rv));
                chk($sformatf("m%0d_err", i), 32'(rsp_err[i]), 32'(rv && m_err[i]));
                if (!rv || m_known[i])
                    chk($sformatf("m%0d_rdata", i), rsp_rdata[i], rv ? m_rdata[i] : 32'd0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic txn(input int i, input string tag, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                       input bit end_rst, input logic [31:0] exp_rd, input bit exp_err);
        bit acc;
        bit got;
        int lat;
        @(posedge clk); #1;
        req_valid[i] = 1'b1; req_wr[i] = wr; req_addr[i] = addr;
        req_wdata[i] = wdata; req_wstrb[i] = strb;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk); acc = req_ready[i];
            @(posedge clk);
        end
        chk({tag, "_accept"}, 32'(acc), 32'd1);
        #1;
        // Scramble fields after accept: the in-flight access must not see them.
        req_valid[i] = 1'b0; req_wr[i] = ~wr; req_addr[i] = 32'hFFFF_FFF3;
        req_wdata[i] = ~wdata; req_wstrb[i] = ~strb;
        lat = 0; got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); lat++;
            @(negedge clk); got = rsp_valid[i];
        end
        chk({tag, "_valid"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(wc(i) + 1));
        chk({tag, "_rdata"}, rsp_rdata[i], exp_rd);
        chk({tag, "_err"}, 32'(rsp_err[i]), 32'(exp_err));
        if (hold > 0) begin
            // Competing request that must not be accepted while busy.
            req_valid[i] = 1'b1; req_wr[i] = 1'b1; req_addr[i] = 32'h10;
            req_wdata[i] = 32'd0; req_wstrb[i] = 4'hF;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(rsp_valid[i]), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata[i], exp_rd);
            chk({tag, "_hold_ready"}, 32'(req_ready[i]), 32'd0);
        end
        req_valid[i] = 1'b0;
        if (end_rst) begin
            rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            chk({tag, "_rst_valid"}, 32'(rsp_valid[i]), 32'd0);
            chk({tag, "_rst_ready"}, 32'(req_ready[i]), 32'd1);
        end else begin
            rsp_ready[i] = 1'b1;
            @(posedge clk); #1 rsp_ready[i] = 1'b0;
            @(negedge clk);
            chk({tag, "_idle_ready"}, 32'(req_ready[i]), 32'd1);
            chk({tag, "_idle_valid"}, 32'(rsp_valid[i]), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_wr[i] = 1'b0; req_addr[i] = 32'd0;
            req_wdata[i] = 32'd0; req_wstrb[i] = 4'd0; rsp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_ready", i), 32'(req_ready[i]), 32'd1);
            chk($sformatf("rst%0d_valid", i), 32'(rsp_valid[i]), 32'd0);
            chk($sformatf("rst%0d_rdata", i), rsp_rdata[i], 32'd0);
            chk($sformatf("rst%0d_err", i), 32'(rsp_err[i]), 32'd0);
        end
        chk_on = 1'b1;

        // WAIT_CYCLES = 1
        txn(0, "w_full",  1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0,        1'b0);
        txn(0, "r_full",  1'b0, 32'h10, 32'h0,        4'hF, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        txn(0, "w_strb",  1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 1'b0, 32'h0,    1'b0);
        txn(0, "r_strb",  1'b0, 32'h10, 32'h0,        4'h0, 0, 1'b0, 32'hDE22BE44, 1'b0);
        txn(0, "r_bp",    1'b0, 32'h10, 32'h0,        4'hF, 5, 1'b0, 32'hDE22BE44, 1'b0);
        txn(0, "r_postbp",1'b0, 32'h10, 32'h0,        4'hF, 0, 1'b0, 32'hDE22BE44, 1'b0);
        txn(0, "w_misal", 1'b1, 32'h12, 32'h0,        4'hF, 0, 1'b0, 32'h0,        1'b1);
        txn(0, "r_postmis",1'b0,32'h10, 32'h0,        4'hF, 0, 1'b0, 32'hDE22BE44, 1'b0);
        txn(0, "r_oob",   1'b0, 32'h1000, 32'h0,      4'hF, 0, 1'b0, 32'h0,        1'b1);
        txn(0, "w_last",  1'b1, 32'hFFC, 32'hA5A5A5A5, 4'hF, 0, 1'b0, 32'h0,       1'b0);
        txn(0, "r_last",  1'b0, 32'hFFC, 32'h0,       4'hF, 0, 1'b0, 32'hA5A5A5A5, 1'b0);
        txn(0, "w_rsprst",1'b1, 32'h30, 32'h55AA55AA, 4'hF, 2, 1'b1, 32'h0,        1'b0);
        txn(0, "r_rsprst",1'b0, 32'h30, 32'h0,        4'hF, 0, 1'b0, 32'h55AA55AA, 1'b0);
        txn(0, "r_final", 1'b0, 32'h10, 32'h0,        4'hF, 0, 1'b0, 32'hDE22BE44, 1'b0);

        // WAIT_CYCLES = 3: reset while in WAIT drops the write
        txn(1, "w_prior", 1'b1, 32'h20, 32'h11111111, 4'hF, 0, 1'b0, 32'h0,        1'b0);
        txn(1, "r_prior", 1'b0, 32'h20, 32'h0,        4'hF, 0, 1'b0, 32'h11111111, 1'b0);
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 32'h20;
        req_wdata[1] = 32'hCAFEF00D; req_wstrb[1] = 4'hF;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_novalid", 32'(rsp_valid[1]), 32'd0);
        end
        txn(1, "r_abort", 1'b0, 32'h20, 32'h0,        4'hF, 0, 1'b0, 32'h11111111, 1'b0);

        // WAIT_CYCLES = 0
        txn(2, "w_z",     1'b1, 32'h40, 32'h01020304, 4'hF, 0, 1'b0, 32'h0,        1'b0);
        txn(2, "w_nostrb",1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 0, 1'b0, 32'h0,        1'b0);
        txn(2, "r_z",     1'b0, 32'h40, 32'h0,        4'hF, 0, 1'b0, 32'h01020304, 1'b0);

        repeat (2) @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
